corelet_ctrl: RTL
=================

// Module: corelet_ctrl
// PURPOSE
//   Instruction sequencer that drives the 35-bit inst bundle consumed by corelet/core.
//   Replaces testbench-generated inst for one full conv tile.
//   Per kernel position kij it runs: weight fetch, weight load, activation fetch, execute, OFIFO drain to PMEM.
//   Optionally follows with an accumulate pass that streams PSUMs from PMEM through the SFU.
// PARAMETERS
//   row      8   MAC array rows; also words per activation vector
//   col      8   MAC array columns; weight vectors per kij
//   NIJ_MAX  64  max activations per tile (L0 depth); nij_len above this is clipped to NIJ_MAX
// PORTS
//   clk          input   1   clock, rising edge
//   reset        input   1   asynchronous, active-low reset
//   start        input   1   one-cycle pulse; sampled only in IDLE
//   kij_num      input   4   kernel positions per tile (1..9); latched at start
//   nij_len      input   7   activation vectors per kij; latched at start
//   w_base       input   11  XMEM weight base address; latched at start
//   a_base       input   11  XMEM activation base address; latched at start
//   p_base       input   11  PMEM PSUM base address; latched at start
//   ofifo_valid  input   1   OFIFO holds a readable PSUM vector
//   inst         output  35  registered instruction bundle to core
//   busy         output  1   high in any state except IDLE
//   done         output  1   one-cycle pulse on return to IDLE
//   sfp_valid    output  1   SFU result valid (accumulate pass); tied 0 without CTRL_ACC_EN
// BEHAVIOUR
//   inst map:
//     [34] bypass (1 = SFU takes OFIFO, 0 = takes PMEM)
//     [33] acc
//     [32] CEN_pmem (active-low)
//     [31] WEN_pmem (active-low)
//     [30:20] A_pmem
//     [19] CEN_xmem (active-low)
//     [18] WEN_xmem (active-low)
//     [17:7] A_xmem
//     [6] ofifo_rd
//     [5] ififo_wr, tied 0
//     [4] ififo_rd, tied 0
//     [3] l0_rd
//     [2] l0_wr
//     [1] execute
//     [0] load
//   IDLE value: 35'h1_800C_0000 (both CENs/WENs high, all else 0). Same value at reset: busy=0, done=0, sfp_valid=0.
//   All outputs are registered. reset low forces IDLE asynchronously from any state.
//   Addresses are 11-bit and wrap mod 2048.
//   FSM: IDLE > W_FETCH > W_LOAD > W_WAIT > A_FETCH > EXEC > DRAIN > (next kij: W_FETCH | ACC | FIN) > IDLE
//   IDLE:
//     - start=1 with kij_num!=0 and nij_len!=0: latch config, k=0, go to W_FETCH.
//     - Zero kij_num or nij_len: go to FIN directly; no memory activity.
//   W_FETCH (col+1 cycles):
//     - Cycles 0..col-1: CEN_xmem=0, WEN_xmem=1, A_xmem = w_base + k*col + i.
//     - l0_wr=1 on cycles 1..col, tracking 1-cycle SRAM read latency.
//   W_LOAD (col cycles): l0_rd=1, load=1.
//   W_WAIT (row+col cycles): inst idle, weights propagate.
//   A_FETCH (n+1 cycles): same pattern as W_FETCH, A_xmem = a_base + j, j=0..n-1.
//   EXEC (n cycles): l0_rd=1, execute=1.
//   DRAIN:
//     - Per cycle with ofifo_valid=1 and reads<n: ofifo_rd=1, bypass=1, CEN_pmem=0, WEN_pmem=0, A_pmem = p_base + k*n + reads.
//     - ofifo_valid=0: hold with no read, no timeout.
//     - After n reads: k++. k<kij_num goes to W_FETCH, else ACC (if enabled) or FIN.
//   FIN: done=1 for exactly one cycle, then IDLE.
//   start while busy is ignored; no queuing.
// CONFIGURATION
//   CTRL_ACC_EN defined: ACC state compiled in. For each output o=0..n-1, for k=0..kij_num-1:
//     - PMEM read: CEN_pmem=0, WEN_pmem=1, A_pmem = p_base + k*n + o, bypass=0.
//     - acc=1 on the cycle after each read (D_pmem valid); on the last k, acc=0 instead (ReLU + clear).
//     - sfp_valid pulses the cycle after acc=0.
//     - Reads are back-to-back, no stall. Exit to FIN after o=n-1.
//   CTRL_ACC_EN undefined: no ACC state, DRAIN goes to FIN, sfp_valid tied 0, inst[33] always 0.
// TESTING
//   1. Assert reset low mid-run -> inst=35'h1_800C_0000, busy=0, done=0 with no clock edge needed.
//   2. start, kij_num=1, nij_len=4, w_base=0, a_base=0x100:
//      - A_xmem 0..7, l0_wr lagging 1 cycle; load 8 cycles.
//      - A_xmem 0x100..0x103; execute 4 cycles.
//   3. In DRAIN, hold ofifo_valid=0 10 cycles then 1 -> ofifo_rd only when valid; PMEM writes at p_base+0..3 with WEN=0.
//   4. kij_num=9, nij_len=36, ofifo_valid=1 -> 324 PMEM writes, addresses p_base..p_base+323.
//      - Second start mid-run ignored; single done pulse.
//   5. start with kij_num=0 -> done pulse 2 cycles later; CEN_xmem/CEN_pmem never low.
//   6. CTRL_ACC_EN, kij_num=3, nij_len=2, p_base=0:
//      - PMEM reads 0,2,4 then 1,3,5.
//      - acc pattern 1,1,0 per output; sfp_valid pulses twice; then done.

Source files
------------

// File: rtl/corelet_ctrl.sv
// ---------------------------------------------------------------------------
// corelet_ctrl
//   Instruction sequencer for one conv tile. It produces the 35-bit inst
//   bundle that corelet/core consumes. For each kernel position it runs:
//   weight fetch, weight load, weight settle, activation fetch, execute,
//   and OFIFO drain into PMEM. With CTRL_ACC_EN defined, an accumulate pass
//   then streams the stored PSUMs from PMEM back through the SFU.
//
//   Build macro: CTRL_ACC_EN (undefined by default; without it there is no
//   accumulate state, sfp_valid is tied 0 and inst[33] is always 0).
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-low reset
//     start        one-cycle start pulse, honoured only in IDLE
//     kij_num      kernel positions per tile, latched at start
//     nij_len      activation vectors per kij, latched at start (clipped)
//     w_base       XMEM weight base address, latched at start
//     a_base       XMEM activation base address, latched at start
//     p_base       PMEM PSUM base address, latched at start
//     ofifo_valid  OFIFO holds a readable PSUM vector
//     inst         registered instruction bundle
//     busy         high whenever the sequencer is not idle
//     done         one-cycle pulse on return to IDLE
//     sfp_valid    SFU result valid during the accumulate pass
// ---------------------------------------------------------------------------
module corelet_ctrl #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int NIJ_MAX = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  kij_num,
   input  logic [6:0]  nij_len,
   input  logic [10:0] w_base,
   input  logic [10:0] a_base,
   input  logic [10:0] p_base,
   input  logic        ofifo_valid,
   output logic [34:0] inst,
   output logic        busy,
   output logic        done,
   output logic        sfp_valid
);

   localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;

   localparam int B_BYPASS   = 34;
   localparam int B_ACC      = 33;
   localparam int B_CEN_P    = 32;
   localparam int B_WEN_P    = 31;
   localparam int B_CEN_X    = 19;
   localparam int B_OFIFO_RD = 6;
   localparam int B_L0_RD    = 3;
   localparam int B_L0_WR    = 2;
   localparam int B_EXEC     = 1;
   localparam int B_LOAD     = 0;

   localparam logic [6:0] NIJ_CAP   = 7'(NIJ_MAX);
   localparam logic [6:0] COL_CNT   = 7'(col);
   localparam logic [6:0] WAIT_LAST = 7'(row + col - 1);

`ifdef CTRL_ACC_EN
   typedef enum logic [3:0] {
      IDLE, W_FETCH, W_LOAD, W_WAIT, A_FETCH, EXEC, DRAIN, ACC, FIN
   } state_t;
`else
   typedef enum logic [3:0] {
      IDLE, W_FETCH, W_LOAD, W_WAIT, A_FETCH, EXEC, DRAIN, FIN
   } state_t;
`endif

   state_t      state, state_d;
   logic [6:0]  cnt, cnt_d;
   logic [3:0]  k, k_d;
   logic [3:0]  kij_q;
   logic [6:0]  n_q;
   logic [10:0] w_q, a_q, p_q;
   logic [34:0] inst_d;
   logic [10:0] k_off_w, k_off_p;
   logic [4:0]  k_next;

   assign k_off_w = 11'(k) * 11'(col);
   assign k_off_p = 11'(k) * 11'(n_q);
   assign k_next  = {1'b0, k} + 5'd1;

`ifdef CTRL_ACC_EN
   logic       acc_rd, acc_pend, acc_last, sfp_pend;
   logic [3:0] kij_last;
   assign kij_last = kij_q - 4'd1;
   assign acc_rd   = (state == ACC) && (cnt < n_q);
`endif

   // Next-state and next-instruction logic. The instruction is computed from
   // the current state and counters, then registered, so inst always lags the
   // state register by one cycle. The fetch phases run one cycle longer than
   // the number of reads so that l0_wr can trail each SRAM read by a cycle.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      k_d     = k;
      inst_d  = INST_IDLE;
      case (state)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               k_d     = '0;
               state_d = (kij_num != 4'd0 && nij_len != 7'd0) ? W_FETCH : FIN;
            end
         end
         W_FETCH: begin
            if (cnt < COL_CNT) begin
               inst_d[B_CEN_X] = 1'b0;
               inst_d[17:7]    = w_q + k_off_w + 11'(cnt);
            end
            if (cnt != 7'd0) inst_d[B_L0_WR] = 1'b1;
            if (cnt == COL_CNT) begin
               cnt_d   = '0;
               state_d = W_LOAD;
            end else begin
               cnt_d = cnt + 7'd1;
            end
         end
         W_LOAD: begin
            inst_d[B_L0_RD] = 1'b1;
            inst_d[B_LOAD]  = 1'b1;
            if (cnt == COL_CNT - 7'd1) begin
               cnt_d   = '0;
               state_d = W_WAIT;
            end else begin
               cnt_d = cnt + 7'd1;
            end
         end
         W_WAIT: begin
            if (cnt == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = A_FETCH;
            end else begin
               cnt_d = cnt + 7'd1;
            end
         end
         A_FETCH: begin
            if (cnt < n_q) begin
               inst_d[B_CEN_X] = 1'b0;
               inst_d[17:7]    = a_q + 11'(cnt);
            end
            if (cnt != 7'd0) inst_d[B_L0_WR] = 1'b1;
            if (cnt == n_q) begin
               cnt_d   = '0;
               state_d = EXEC;
            end else begin
               cnt_d = cnt + 7'd1;
            end
         end
         EXEC: begin
            inst_d[B_L0_RD] = 1'b1;
            inst_d[B_EXEC]  = 1'b1;
            if (cnt == n_q - 7'd1) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt + 7'd1;
            end
         end
         DRAIN: begin
            // Stall indefinitely on an empty OFIFO; each read goes straight
            // to PMEM through the SFU bypass path.
            if (ofifo_valid) begin
               inst_d[B_OFIFO_RD] = 1'b1;
               inst_d[B_BYPASS]   = 1'b1;
               inst_d[B_CEN_P]    = 1'b0;
               inst_d[B_WEN_P]    = 1'b0;
               inst_d[30:20]      = p_q + k_off_p + 11'(cnt);
               if (cnt == n_q - 7'd1) begin
                  cnt_d = '0;
                  if (k_next < {1'b0, kij_q}) begin
                     k_d     = k_next[3:0];
                     state_d = W_FETCH;
                  end else begin
                     k_d     = '0;
`ifdef CTRL_ACC_EN
                     state_d = ACC;
`else
                     state_d = FIN;
`endif
                  end
               end else begin
                  cnt_d = cnt + 7'd1;
               end
            end
         end
`ifdef CTRL_ACC_EN
         ACC: begin
            // cnt walks the output index, k walks kernel positions for that
            // output. Once all reads are issued, stay until the acc/sfp
            // pipeline has emptied so done follows the last SFU result.
            if (cnt < n_q) begin
               inst_d[B_CEN_P] = 1'b0;
               inst_d[30:20]   = p_q + k_off_p + 11'(cnt);
               if (k == kij_last) begin
                  k_d   = '0;
                  cnt_d = cnt + 7'd1;
               end else begin
                  k_d = k + 4'd1;
               end
            end else if (!acc_pend && !sfp_pend) begin
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef CTRL_ACC_EN
      // acc follows the PMEM read by one cycle; the last kernel position of
      // each output drops acc so the SFU applies ReLU and clears.
      inst_d[B_ACC] = acc_pend & ~acc_last;
`endif
   end

   // State, counters, latched tile configuration and registered outputs.
   // Configuration is captured only when a start is accepted in IDLE, so
   // input changes during a run have no effect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         k     <= '0;
         kij_q <= '0;
         n_q   <= '0;
         w_q   <= '0;
         a_q   <= '0;
         p_q   <= '0;
         inst  <= INST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         k     <= k_d;
         inst  <= inst_d;
         busy  <= (state != IDLE);
         done  <= (state == FIN);
         if (state == IDLE && start) begin
            kij_q <= kij_num;
            n_q   <= (nij_len > NIJ_CAP) ? NIJ_CAP : nij_len;
            w_q   <= w_base;
            a_q   <= a_base;
            p_q   <= p_base;
         end
      end
   end

`ifdef CTRL_ACC_EN
   // Accumulate-pass pipeline: a read marks the next cycle for acc, and the
   // final read of an output marks the cycle after that for sfp_valid.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_pend  <= 1'b0;
         acc_last  <= 1'b0;
         sfp_pend  <= 1'b0;
         sfp_valid <= 1'b0;
      end else begin
         acc_pend  <= acc_rd;
         acc_last  <= (k == kij_last);
         sfp_pend  <= acc_pend & acc_last;
         sfp_valid <= sfp_pend;
      end
   end
`else
   assign sfp_valid = 1'b0;
`endif

endmodule
